// File: rtl/banked_memory.sv
// Byte memory on the CPU bus: a fixed bank-0 window plus a switchable bank window.
// The bank register sits at its own bus address. Reads complete after a configurable latency.

module banked_memory_chk #(
  parameter int unsigned DEPTH = 1
) (
  input logic        clk,
  input logic        i_valid,
  input logic [31:0] i_phys
);

  // Mapping arithmetic must never leave the storage array
  always @(posedge clk) begin
    if (i_valid) begin
      assert (i_phys < DEPTH);
    end
  end

endmodule

module banked_memory #(
  parameter logic [15:0] START_ADDR    = 16'hC000,
  parameter logic [15:0] BANK_WIN_ADDR = 16'hD000,
  parameter logic [15:0] END_ADDR      = 16'hDFFF,
  parameter int unsigned NUM_BANKS     = 8,
  parameter logic [15:0] BANK_REG_ADDR = 16'hFF70,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        hit,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic [2:0]  bank
);

  localparam int unsigned BANK_SIZE  = 32'(BANK_WIN_ADDR - START_ADDR);
  // With a single bank the window is a second fixed bank, so two banks of storage exist
  localparam int unsigned PHYS_BANKS = (NUM_BANKS > 1) ? NUM_BANKS : 2;
  localparam int unsigned DEPTH      = PHYS_BANKS * BANK_SIZE;
  localparam int unsigned AW         = $clog2(DEPTH);
  localparam int unsigned BW         = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_ACK} state_t;

  logic [7:0]    r_mem [DEPTH];
  state_t        r_state;
  logic [BW-1:0] r_bank_reg;
  logic [1:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_is_reg;
  logic          r_busy;
  logic          r_ack;
  logic [7:0]    r_rdata;

  logic          w_in_range;
  logic          w_is_reg;
  logic          w_in_win;
  logic [2:0]    w_eff;
  logic [2:0]    w_win_bank;
  logic [15:0]   w_off;
  logic [31:0]   w_phys;
  logic [7:0]    w_reg_val;
  logic          w_accept;

  // Address decode and bank mapping
  always_comb begin
    w_in_range = (addr >= START_ADDR) && (addr <= END_ADDR);
    w_is_reg   = (NUM_BANKS > 1) && (addr == BANK_REG_ADDR);
    w_in_win   = (addr >= BANK_WIN_ADDR);
    w_eff      = 3'd0;
    w_win_bank = 3'd1;
    if (NUM_BANKS > 1) begin
      w_eff      = (r_bank_reg == '0) ? 3'd1 : 3'(r_bank_reg);
      w_win_bank = w_eff;
    end else begin
      w_eff      = 3'd0;
      w_win_bank = 3'd1;
    end
    if (w_in_win) begin
      w_off  = addr - BANK_WIN_ADDR;
      w_phys = 32'(w_win_bank) * BANK_SIZE + 32'(w_off);
    end else begin
      w_off  = addr - START_ADDR;
      w_phys = 32'(w_off);
    end
    w_reg_val = {{(8-BW){1'b1}}, r_bank_reg};
    w_accept  = (r_state == S_IDLE) && req && (w_in_range || w_is_reg);
  end

  assign hit   = w_in_range || w_is_reg;
  assign busy  = r_busy;
  assign ack   = r_ack;
  assign rdata = r_rdata;
  assign bank  = w_eff;

  // Storage is left out of reset; a write commits on its accept edge
  always_ff @(posedge clk) begin
    if (w_accept && we && !w_is_reg) begin
      r_mem[w_phys[AW-1:0]] <= wdata;
    end
  end

  // Transaction FSM, bank register and registered bus outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bank_reg <= '0;
      r_cnt      <= 2'd0;
      r_idx      <= '0;
      r_is_reg   <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_rdata    <= 8'hFF;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (we) begin
              if (w_is_reg) begin
                r_bank_reg <= wdata[BW-1:0];
              end
              r_state <= S_ACK;
              r_ack   <= 1'b1;
            end else begin
              r_idx    <= w_phys[AW-1:0];
              r_is_reg <= w_is_reg;
              r_cnt    <= 2'(READ_LATENCY - 1);
              if (READ_LATENCY == 1) begin
                r_state <= S_ACK;
                r_ack   <= 1'b1;
                r_rdata <= w_is_reg ? w_reg_val : r_mem[w_phys[AW-1:0]];
              end else begin
                r_state <= S_RD_WAIT;
              end
            end
          end
        end
        S_RD_WAIT: begin
          // The final decrement and the move to ACK share one edge
          if (r_cnt <= 2'd1) begin
            r_cnt   <= 2'd0;
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            r_rdata <= r_is_reg ? w_reg_val : r_mem[r_idx];
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ack   <= 1'b0;
          r_rdata <= 8'hFF;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ack   <= 1'b0;
          r_rdata <= 8'hFF;
        end
      endcase
    end
  end

  banked_memory_chk #(.DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .i_valid (w_accept && !w_is_reg),
    .i_phys  (w_phys)
  );

endmodule

// File: tb/tb_banked_memory.sv
// Directed bench for banked_memory: default 8-bank part, a READ_LATENCY=3 part
// and a single-bank part share the bus inputs; each has its own req.

module tb_banked_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, req_c, we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        hit_a, busy_a, ack_a, hit_b, busy_b, ack_b, hit_c, busy_c, ack_c;
  logic [7:0]  rdata_a, rdata_b, rdata_c;
  logic [2:0]  bank_a, bank_b, bank_c;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  banked_memory u_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .hit(hit_a), .busy(busy_a), .ack(ack_a), .rdata(rdata_a), .bank(bank_a)
  );

  banked_memory #(.READ_LATENCY(3)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .hit(hit_b), .busy(busy_b), .ack(ack_b), .rdata(rdata_b), .bank(bank_b)
  );

  banked_memory #(.NUM_BANKS(1)) u_c (
    .clk(clk), .reset(reset), .req(req_c), .we(we), .addr(addr), .wdata(wdata),
    .hit(hit_c), .busy(busy_c), .ack(ack_c), .rdata(rdata_c), .bank(bank_c)
  );

  function automatic logic get_ack(input int sel);
    case (sel)
      0:       return ack_a;
      1:       return ack_b;
      default: return ack_c;
    endcase
  endfunction

  function automatic logic [7:0] get_rdata(input int sel);
    case (sel)
      0:       return rdata_a;
      1:       return rdata_b;
      default: return rdata_c;
    endcase
  endfunction

  task automatic set_req(input int sel, input logic v);
    case (sel)
      0:       req_a = v;
      1:       req_b = v;
      default: req_c = v;
    endcase
  endtask

  // One bus transaction; lat counts edges from the accept edge (=1) to ack, 0 on timeout
  task automatic do_access(input int sel, input logic w, input logic [15:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd,
                           output logic ack_after, output logic [7:0] rd_after);
    lat = 0;
    rd  = 8'h00;
    @(negedge clk);
    addr = a; we = w; wdata = d;
    set_req(sel, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (get_ack(sel)) begin
        lat = i;
        rd  = get_rdata(sel);
        break;
      end
    end
    @(negedge clk);
    set_req(sel, 1'b0);
    @(posedge clk); #1;
    ack_after = get_ack(sel);
    rd_after  = get_rdata(sel);
  endtask

  task automatic test_reset();
    int lat; logic [7:0] rd, rda; logic acka;
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    we = 1'b0; addr = 16'h0000; wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_checks++; if (ack_a !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", ack_a); end
    n_checks++; if (rdata_a !== 8'hFF) begin n_fail++; $display("FAIL reset_rdata: got %h want ff", rdata_a); end
    n_checks++; if (bank_a !== 3'd1) begin n_fail++; $display("FAIL reset_bank: got %0d want 1", bank_a); end
    n_checks++; if (bank_c !== 3'd0) begin n_fail++; $display("FAIL reset_bank_single: got %0d want 0", bank_c); end
    @(negedge clk);
    reset = 1'b1;
    do_access(1, 1'b1, 16'hFF70, 8'h04, lat, rd, acka, rda);
    n_checks++; if (bank_b !== 3'd4) begin n_fail++; $display("FAIL bank_set_b: got %0d want 4", bank_b); end
    // Start a latency-3 read and pull reset while it sits in RD_WAIT
    @(negedge clk);
    addr = 16'hC000; we = 1'b0; req_b = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({busy_b, ack_b} !== 2'b10) begin n_fail++; $display("FAIL rdwait_state: got busy/ack %b want 10", {busy_b, ack_b}); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b want 0", busy_b); end
    n_checks++; if (ack_b !== 1'b0) begin n_fail++; $display("FAIL async_ack: got %b want 0", ack_b); end
    n_checks++; if (rdata_b !== 8'hFF) begin n_fail++; $display("FAIL async_rdata: got %h want ff", rdata_b); end
    n_checks++; if (bank_b !== 3'd1) begin n_fail++; $display("FAIL async_bank: got %0d want 1", bank_b); end
    req_b = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_read_write();
    int lat; logic [7:0] rd, rda; logic acka;
    do_access(0, 1'b1, 16'hC010, 8'h5A, lat, rd, acka, rda);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL wr_lat: got %0d want 1", lat); end
    n_checks++; if (rd !== 8'hFF) begin n_fail++; $display("FAIL wr_rdata: got %h want ff", rd); end
    do_access(0, 1'b0, 16'hC010, 8'h00, lat, rd, acka, rda);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rd_lat1: got %0d want 1", lat); end
    n_checks++; if (rd !== 8'h5A) begin n_fail++; $display("FAIL rd_data1: got %h want 5a", rd); end
    n_checks++; if (acka !== 1'b0) begin n_fail++; $display("FAIL ack_pulse: got %b want 0", acka); end
    n_checks++; if (rda !== 8'hFF) begin n_fail++; $display("FAIL rdata_idle: got %h want ff", rda); end
    do_access(1, 1'b1, 16'hC010, 8'h3C, lat, rd, acka, rda);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL wr_lat_b: got %0d want 1", lat); end
    do_access(1, 1'b0, 16'hC010, 8'h00, lat, rd, acka, rda);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rd_lat3: got %0d want 3", lat); end
    n_checks++; if (rd !== 8'h3C) begin n_fail++; $display("FAIL rd_data3: got %h want 3c", rd); end
  endtask

  task automatic test_banking();
    int lat; logic [7:0] rd, rda; logic acka;
    do_access(0, 1'b1, 16'hC000, 8'h99, lat, rd, acka, rda);
    do_access(0, 1'b1, 16'hFF70, 8'h02, lat, rd, acka, rda);
    do_access(0, 1'b1, 16'hD000, 8'h11, lat, rd, acka, rda);
    do_access(0, 1'b1, 16'hFF70, 8'h03, lat, rd, acka, rda);
    do_access(0, 1'b1, 16'hD000, 8'h22, lat, rd, acka, rda);
    n_checks++; if (bank_a !== 3'd3) begin n_fail++; $display("FAIL bank3: got %0d want 3", bank_a); end
    do_access(0, 1'b0, 16'hD000, 8'h00, lat, rd, acka, rda);
    n_checks++; if (rd !== 8'h22) begin n_fail++; $display("FAIL bank3_data: got %h want 22", rd); end
    do_access(0, 1'b1, 16'hFF70, 8'h02, lat, rd, acka, rda);
    do_access(0, 1'b0, 16'hD000, 8'h00, lat, rd, acka, rda);
    n_checks++; if (rd !== 8'h11) begin n_fail++; $display("FAIL bank2_data: got %h want 11", rd); end
    do_access(0, 1'b0, 16'hC000, 8'h00, lat, rd, acka, rda);
    n_checks++; if (rd !== 8'h99) begin n_fail++; $display("FAIL fixed_data: got %h want 99", rd); end
  endtask

  task automatic test_alias();
    int lat; logic [7:0] rd, rda; logic acka;
    do_access(0, 1'b1, 16'hFF70, 8'h00, lat, rd, acka, rda);
    n_checks++; if (bank_a !== 3'd1) begin n_fail++; $display("FAIL alias_bank: got %0d want 1", bank_a); end
    do_access(0, 1'b1, 16'hD004, 8'h77, lat, rd, acka, rda);
    do_access(0, 1'b1, 16'hFF70, 8'h01, lat, rd, acka, rda);
    do_access(0, 1'b0, 16'hD004, 8'h00, lat, rd, acka, rda);
    n_checks++; if (rd !== 8'h77) begin n_fail++; $display("FAIL alias_data: got %h want 77", rd); end
    // Only the low three bits are stored; reads return 5 ones above the stored value
    do_access(0, 1'b1, 16'hFF70, 8'hF5, lat, rd, acka, rda);
    n_checks++; if (bank_a !== 3'd5) begin n_fail++; $display("FAIL reg5_bank: got %0d want 5", bank_a); end
    do_access(0, 1'b0, 16'hFF70, 8'h00, lat, rd, acka, rda);
    n_checks++; if (rd !== 8'hFD) begin n_fail++; $display("FAIL reg_read: got %h want fd", rd); end
    do_access(0, 1'b1, 16'hDFFF, 8'hE1, lat, rd, acka, rda);
    do_access(0, 1'b0, 16'hDFFF, 8'h00, lat, rd, acka, rda);
    n_checks++; if (rd !== 8'hE1) begin n_fail++; $display("FAIL end_addr: got %h want e1", rd); end
    @(negedge clk);
    addr = 16'hBFFF;
    #1;
    n_checks++; if (hit_a !== 1'b0) begin n_fail++; $display("FAIL below_start_hit: got %b want 0", hit_a); end
  endtask

  task automatic test_miss();
    int lat; logic [7:0] rd, rda; logic acka;
    logic [15:0] miss_addrs [2];
    logic seen;
    miss_addrs[0] = 16'hE000;
    miss_addrs[1] = 16'hFF71;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      addr = miss_addrs[k]; we = 1'b0; req_a = 1'b1;
      #1;
      n_checks++; if (hit_a !== 1'b0) begin n_fail++; $display("FAIL miss_hit %h: got %b want 0", miss_addrs[k], hit_a); end
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (ack_a || busy_a) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL miss_ack %h: got activity %b want 0", miss_addrs[k], seen); end
      @(negedge clk);
      req_a = 1'b0;
    end
    do_access(0, 1'b0, 16'hC010, 8'h00, lat, rd, acka, rda);
    n_checks++; if (lat !== 1 || rd !== 8'h5A) begin n_fail++; $display("FAIL post_miss: got lat %0d data %h want 1 5a", lat, rd); end
  endtask

  task automatic test_single_bank();
    int lat; logic [7:0] rd, rda; logic acka;
    logic seen;
    @(negedge clk);
    addr = 16'hFF70; we = 1'b1; wdata = 8'h03; req_c = 1'b1;
    #1;
    n_checks++; if (hit_c !== 1'b0) begin n_fail++; $display("FAIL single_reg_hit: got %b want 0", hit_c); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack_c || busy_c) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL single_reg_ack: got activity %b want 0", seen); end
    @(negedge clk);
    req_c = 1'b0;
    do_access(2, 1'b1, 16'hD000, 8'hA5, lat, rd, acka, rda);
    do_access(2, 1'b1, 16'hC000, 8'h5A, lat, rd, acka, rda);
    do_access(2, 1'b0, 16'hD000, 8'h00, lat, rd, acka, rda);
    n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL single_win: got %h want a5", rd); end
    do_access(2, 1'b0, 16'hC000, 8'h00, lat, rd, acka, rda);
    n_checks++; if (rd !== 8'h5A) begin n_fail++; $display("FAIL single_fixed: got %h want 5a", rd); end
    n_checks++; if (bank_c !== 3'd0) begin n_fail++; $display("FAIL single_bank: got %0d want 0", bank_c); end
  endtask

  initial begin
    test_reset();
    test_read_write();
    test_banking();
    test_alias();
    test_miss();
    test_single_bank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
